scan_chain_driver: RTL and testbench
====================================

# scan_chain_driver

Initiator side of the boundary-scan chain fabric: accepts a chain-access request (chain index, length, write word), drives one capture-shift-update sequence into the multiplexed BSC chain array, and returns the bits shifted out of the selected chain. Sits between the test controller and the multi-chain BSC block, generating the capture, shift, update, mode and mux-select controls that block consumes.

## Interface
- NUM_CHAINS, 4, number of selectable chains
- SEL_W, 2, width of chain select (clog2 NUM_CHAINS)
- MAX_LEN, 16, longest supported chain in scan cells
- LEN_W, 5, width of length field (holds 0..MAX_LEN)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request strobe, sampled only in IDLE
- chain_sel  in  SEL_W  target chain
- chain_len  in  LEN_W  cells in target chain
- wr_data  in  MAX_LEN  bits to shift in, bit 0 first
- do_update  in  1  1 = perform UPDATE after shift
- test_mode  in  1  value for mode output during the access
- busy  out  1  high from cycle after accepted start through DONE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse with done on rejected request
- rd_data  out  MAX_LEN  captured shift-out bits, bit 0 first; upper bits zero
- mux_select  out  SEL_W  chain select to chain array
- capture_en  out  1  capture enable
- shift_dr  out  1  shift enable
- update_en  out  1  update enable
- mode  out  1  test-mode select
- scan_out  out  1  serial data to selected chain input
- scan_in  in  1  serial data from selected chain output

## Operation
- Reset: state IDLE; busy, done, error, capture_en, shift_dr, update_en, mode, scan_out = 0; mux_select = 0; rd_data = 0.
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE: on start, latch chain_sel, chain_len, wr_data, do_update, test_mode. Valid length (1..MAX_LEN) -> CAPTURE. Invalid (0 or >MAX_LEN) -> DONE with error, no control pulses, rd_data unchanged.
- CAPTURE: capture_en = 1 for exactly one cycle; bit counter cleared; rd_data cleared -> SHIFT.
- SHIFT: shift_dr = 1; in shift cycle k, scan_out = wr_data[k]; scan_in sampled at end of cycle into rd_data[k]. After k = len-1 -> UPDATE if do_update, else DONE.
- UPDATE: update_en = 1 for one cycle -> DONE.
- DONE: done = 1 one cycle (error too if rejected); busy still 1 -> IDLE.
- mux_select and mode hold latched values from CAPTURE through DONE; they retain their value in IDLE until next accepted start.
- start while busy: ignored, not queued. Inputs other than scan_in ignored while busy.
- capture_en, shift_dr, update_en mutually exclusive every cycle; scan_out = 0 outside SHIFT.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, no done pulse; partial rd_data discarded.

## Timing
- All outputs registered.
- start sampled at edge 0 -> CAPTURE in cycle 1, SHIFT cycles 2..len+1, UPDATE cycle len+2 (if enabled), done in cycle len+3 (len+2 without update).
- Rejected request: done and error in cycle 1.
- rd_data stable and valid from done cycle until next accepted start.
- Earliest next start: cycle after done (back-to-back, one idle cycle).
- Counter width LEN_W; terminal compare against latched len-1, no wrap.

## Structure
- Shared package: state encoding enum, MAX_LEN, LEN_W, SEL_W defaults shared with the chain array.
- One sub-module natural: scan_shift_reg (MAX_LEN-bit parallel-load/serial shift register with bit counter), used for both wr_data unload and rd_data assembly; FSM in the top.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, busy never asserts.
- chain_sel=2, chain_len=4, wr_data=0x000A, do_update=1, scan_in looped from 4-cell model preloaded 0x3 -> mux_select=2, scan_out 0,1,0,1 over cycles 2..5, update_en cycle 6, done cycle 7, rd_data=0x0003.
- chain_len=16, wr_data=0xBEEF, do_update=0, model preloaded 0x1234 -> no update_en, done cycle 18, rd_data=0x1234, model holds 0xBEEF.
- chain_len=0 and chain_len=17 -> done+error in cycle 1, no capture/shift/update pulses.
- start asserted every cycle during an 8-cell access -> exactly one access, second accepted only after done.
- reset in cycle 4 of a 10-cell shift -> next cycle IDLE, all outputs 0, no done pulse; fresh access then completes normally.

Source files
------------

// File: rtl/scan_chain_driver_pkg.sv
// Shared definitions for the scan chain driver and the multi-chain BSC array.
// Holds the chain geometry defaults, the driver FSM state encoding and a
// length-validity helper used when a request is accepted.
package scan_chain_driver_pkg;

  localparam int unsigned NUM_CHAINS = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned MAX_LEN    = 16;
  localparam int unsigned LEN_W      = 5;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StDone
  } state_e;

  // A chain access must cover at least one cell and no more than MAX_LEN.
  function automatic logic len_valid(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/scan_chain_driver_if.sv
// Request/response bundle between the test controller and the scan chain driver.
//   master : test controller (drives the request, observes status and read data)
//   slave  : scan chain driver
// Signals: start, chain_sel, chain_len, wr_data, do_update, test_mode (request);
//          busy, done, error, rd_data (response).
interface scan_chain_driver_if;
  import scan_chain_driver_pkg::*;

  logic               start;
  logic [SEL_W-1:0]   chain_sel;
  logic [LEN_W-1:0]   chain_len;
  logic [MAX_LEN-1:0] wr_data;
  logic               do_update;
  logic               test_mode;
  logic               busy;
  logic               done;
  logic               error;
  logic [MAX_LEN-1:0] rd_data;

  modport master (
    output start, chain_sel, chain_len, wr_data, do_update, test_mode,
    input  busy, done, error, rd_data
  );

  modport slave (
    input  start, chain_sel, chain_len, wr_data, do_update, test_mode,
    output busy, done, error, rd_data
  );

endinterface

// File: rtl/scan_chain_driver_shift_reg.sv
// Scan shift register: parallel-loads the write word and unloads it LSB first,
// while assembling the returned bits into a parallel read word by bit counter.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   load_i          : load load_data_i into the write register
//   clear_i         : clear read word and bit counter
//   shift_i         : advance one scan cell (unload one bit, capture sin_i)
//   sin_i           : serial bit returning from the chain
//   sout_next_o     : bit that will be presented on the chain input next cycle
//   rd_data_o       : assembled read word, bit 0 first
//   cnt_o           : number of bits shifted since the last clear
module scan_chain_driver_shift_reg
  import scan_chain_driver_pkg::*;
#(
  parameter int unsigned Width = MAX_LEN,
  parameter int unsigned CntW  = LEN_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic             sout_next_o,
  output logic [Width-1:0] rd_data_o,
  output logic [CntW-1:0]  cnt_o
);

  localparam int unsigned IdxW = $clog2(Width);

  logic [Width-1:0] wr_q;
  logic [Width-1:0] rd_q;
  logic [CntW-1:0]  cnt_q;

  // While shifting, bit 1 moves into position 0 on this edge.
  assign sout_next_o = shift_i ? wr_q[1] : wr_q[0];
  assign rd_data_o   = rd_q;
  assign cnt_o       = cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) begin
        wr_q <= load_data_i;
      end else if (shift_i) begin
        wr_q <= wr_q >> 1;
      end
      if (clear_i) begin
        rd_q  <= '0;
        cnt_q <= '0;
      end else if (shift_i) begin
        rd_q[cnt_q[IdxW-1:0]] <= sin_i;
        cnt_q                 <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Boundary-scan chain initiator. Accepts one chain-access request, runs a
// capture-shift-update sequence on the selected chain and returns the bits
// shifted out.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req          : controller request/response bundle (slave side)
//   mux_select   : chain select to the chain array
//   capture_en   : capture enable
//   shift_dr     : shift enable
//   update_en    : update enable
//   mode         : test-mode select
//   scan_out     : serial data into the selected chain
//   scan_in      : serial data from the selected chain
module scan_chain_driver
  import scan_chain_driver_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  scan_chain_driver_if.slave   req,
  output logic [SEL_W-1:0]     mux_select,
  output logic                 capture_en,
  output logic                 shift_dr,
  output logic                 update_en,
  output logic                 mode,
  output logic                 scan_out,
  input  logic                 scan_in
);

  state_e state_q, state_d;

  logic [SEL_W-1:0] sel_q;
  logic [LEN_W-1:0] len_q;
  logic             upd_q;
  logic             mode_q;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic capture_q, capture_d;
  logic shift_q, shift_d;
  logic update_q, update_d;
  logic scan_out_q, scan_out_d;

  logic             len_ok;
  logic             accept;
  logic             last_bit;
  logic             sr_clear;
  logic             sr_shift;
  logic             sout_next;
  logic [LEN_W-1:0] bit_cnt;

  assign len_ok   = len_valid(req.chain_len);
  assign accept   = (state_q == StIdle) && req.start && len_ok;
  assign last_bit = (bit_cnt == len_q - LEN_W'(1));
  assign sr_clear = (state_q == StCapture);
  assign sr_shift = (state_q == StShift);

  scan_chain_driver_shift_reg #(
    .Width (MAX_LEN),
    .CntW  (LEN_W)
  ) u_shift_reg (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (accept),
    .load_data_i (req.wr_data),
    .clear_i     (sr_clear),
    .shift_i     (sr_shift),
    .sin_i       (scan_in),
    .sout_next_o (sout_next),
    .rd_data_o   (req.rd_data),
    .cnt_o       (bit_cnt)
  );

  // Outputs are registered from the next state so each pulse lines up with
  // the cycle its state occupies.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req.start) state_d = len_ok ? StCapture : StDone;
      StCapture: state_d = StShift;
      StShift:   if (last_bit) state_d = upd_q ? StUpdate : StDone;
      StUpdate:  state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    // Only a rejected request goes straight from idle to done.
    error_d    = (state_q == StIdle) && req.start && !len_ok;
    capture_d  = (state_d == StCapture);
    shift_d    = (state_d == StShift);
    update_d   = (state_d == StUpdate);
    scan_out_d = (state_d == StShift) && sout_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      len_q      <= '0;
      upd_q      <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      capture_q  <= 1'b0;
      shift_q    <= 1'b0;
      update_q   <= 1'b0;
      scan_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      capture_q  <= capture_d;
      shift_q    <= shift_d;
      update_q   <= update_d;
      scan_out_q <= scan_out_d;
      // Select and mode only follow accepted requests; rejected ones leave
      // the chain array untouched.
      if (accept) begin
        sel_q  <= req.chain_sel;
        len_q  <= req.chain_len;
        upd_q  <= req.do_update;
        mode_q <= req.test_mode;
      end
    end
  end

  assign req.busy   = busy_q;
  assign req.done   = done_q;
  assign req.error  = error_q;
  assign mux_select = sel_q;
  assign mode       = mode_q;
  assign capture_en = capture_q;
  assign shift_dr   = shift_q;
  assign update_en  = update_q;
  assign scan_out   = scan_out_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: a behavioural multi-chain model closes the
// scan loop; expected completions are queued at request time and retired on done.
module tb_scan_chain_driver;
  import scan_chain_driver_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_chain_driver_if bus ();

  logic [SEL_W-1:0] mux_select;
  logic             capture_en;
  logic             shift_dr;
  logic             update_en;
  logic             mode;
  logic             scan_out;
  logic             scan_in;

  scan_chain_driver dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus),
    .mux_select (mux_select),
    .capture_en (capture_en),
    .shift_dr   (shift_dr),
    .update_en  (update_en),
    .mode       (mode),
    .scan_out   (scan_out),
    .scan_in    (scan_in)
  );

  // Chain array model: cell 0 drives scan_in, scan_out enters the last cell.
  logic [15:0] cells [NUM_CHAINS];
  logic [4:0]  mlen  [NUM_CHAINS];
  logic        pl_en;
  logic [1:0]  pl_sel;
  logic [15:0] pl_val;
  logic [4:0]  pl_len;
  logic [15:0] cur;
  logic [15:0] shifted;
  logic [3:0]  top_idx;

  always_comb begin
    cur     = cells[mux_select];
    top_idx = 4'(mlen[mux_select] - 5'd1);
    shifted = cur >> 1;
    shifted[top_idx] = scan_out;
  end
  assign scan_in = cur[0];

  always_ff @(posedge clk) begin
    if (pl_en) begin
      cells[pl_sel] <= pl_val;
      mlen[pl_sel]  <= pl_len;
    end else if (shift_dr) begin
      cells[mux_select] <= shifted;
    end
  end

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_rd   = '0;
  logic [1:0]  last_sel  = '0;
  logic        last_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_retire(input string tag, input int lat);
    exp_t e;
    check_val({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({tag, "_done_cycle"}, 32'(lat), 32'(e.lat));
      check_val({tag, "_error"}, 32'(bus.error), 32'(e.err));
      check_val({tag, "_rd_data"}, 32'(bus.rd_data), 32'(e.rd));
    end
  endtask

  task automatic preload(input logic [1:0] sel, input logic [4:0] len, input logic [15:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_sel = sel;
    pl_len = len;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic run_access(input string tag, input logic [1:0] sel, input logic [4:0] len,
                            input logic [15:0] wr, input logic upd, input logic md,
                            input logic [15:0] exp_rd);
    exp_t        e;
    logic        ok_len;
    int          got_lat, n_cap, n_upd, n_shift, upd_cyc;
    logic [15:0] so_bits, mask;
    logic        excl_bad, so_bad, ctl_bad, busy_bad;
    ok_len = (len != 5'd0) && (len <= 5'd16);
    e.rd   = ok_len ? exp_rd : last_rd;
    e.err  = !ok_len;
    e.lat  = !ok_len ? 1 : (upd ? int'(len) + 3 : int'(len) + 2);
    sb.push_back(e);
    mask = (len >= 5'd16) ? 16'hFFFF : 16'((32'd1 << len) - 32'd1);
    got_lat = -1; n_cap = 0; n_upd = 0; n_shift = 0; upd_cyc = -1; so_bits = '0;
    excl_bad = 1'b0; so_bad = 1'b0; ctl_bad = 1'b0; busy_bad = 1'b0;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.chain_sel = sel;
    bus.chain_len = len;
    bus.wr_data   = wr;
    bus.do_update = upd;
    bus.test_mode = md;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    // Scramble request fields while busy; they must be ignored.
    bus.chain_sel = 2'($urandom);
    bus.wr_data   = 16'($urandom);
    bus.test_mode = ~md;
    for (int c = 1; c <= 40; c++) begin
      if (capture_en) n_cap++;
      if (update_en) begin n_upd++; upd_cyc = c; end
      if (shift_dr) begin
        n_shift++;
        if (c >= 2 && c <= 17) so_bits[c-2] = scan_out;
      end
      if (int'(capture_en) + int'(shift_dr) + int'(update_en) > 1) excl_bad = 1'b1;
      if (scan_out && !shift_dr) so_bad = 1'b1;
      if (ok_len && (mux_select !== sel || mode !== md)) ctl_bad = 1'b1;
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (bus.done === 1'b1) begin got_lat = c; break; end
      @(negedge clk);
    end
    sb_retire(tag, got_lat);
    check_val({tag, "_capture_pulses"}, 32'(n_cap), ok_len ? 32'd1 : 32'd0);
    check_val({tag, "_shift_cycles"}, 32'(n_shift), ok_len ? 32'(len) : 32'd0);
    check_val({tag, "_update_pulses"}, 32'(n_upd), (ok_len && upd) ? 32'd1 : 32'd0);
    if (ok_len && upd) check_val({tag, "_update_cycle"}, 32'(upd_cyc), 32'(len) + 32'd2);
    if (ok_len) check_val({tag, "_scan_out_bits"}, 32'(so_bits & mask), 32'(wr & mask));
    check_val({tag, "_ctl_exclusive"}, 32'(excl_bad), 32'd0);
    check_val({tag, "_scan_out_idle"}, 32'(so_bad), 32'd0);
    if (ok_len) check_val({tag, "_sel_mode_hold"}, 32'(ctl_bad), 32'd0);
    check_val({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    check_val({tag, "_idle_status"}, 32'({bus.busy, bus.done, bus.error}), 32'd0);
    check_val({tag, "_sel_retained"}, 32'(mux_select), ok_len ? 32'(sel) : 32'(last_sel));
    check_val({tag, "_mode_retained"}, 32'(mode), ok_len ? 32'(md) : 32'(last_mode));
    check_val({tag, "_rd_stable"}, 32'(bus.rd_data), 32'(e.rd));
    last_rd = e.rd;
    if (ok_len) begin last_sel = sel; last_mode = md; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] acc;
    int          n_cap, n_done, cap2, base;
    logic        busy_seen;

    pl_en = 1'b0; pl_sel = '0; pl_len = '0; pl_val = '0;
    bus.start = 1'b0; bus.chain_sel = '0; bus.chain_len = '0; bus.wr_data = '0;
    bus.do_update = 1'b0; bus.test_mode = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", 32'({bus.busy, bus.done, bus.error, capture_en, shift_dr,
              update_en, mode, scan_out, mux_select}), 32'd0);
    check_val("reset_rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b0;
    acc = '0; busy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      acc |= {bus.rd_data[15:9] | bus.rd_data[8:2], bus.busy, bus.done, bus.error, capture_en,
              shift_dr, update_en, mode, scan_out, mux_select};
      busy_seen |= bus.busy;
    end
    check_val("idle_outputs", 32'(acc), 32'd0);
    check_val("idle_busy", 32'(busy_seen), 32'd0);

    preload(2'd2, 5'd4, 16'h0003);
    run_access("len4_upd", 2'd2, 5'd4, 16'h000A, 1'b1, 1'b1, 16'h0003);
    check_val("len4_chain_holds_wr", 32'(cells[2] & 16'h000F), 32'h000A);

    preload(2'd1, 5'd16, 16'h1234);
    run_access("len16_noupd", 2'd1, 5'd16, 16'hBEEF, 1'b0, 1'b0, 16'h1234);
    check_val("len16_chain_holds_wr", 32'(cells[1]), 32'hBEEF);

    run_access("len0_reject", 2'd3, 5'd0, 16'hFFFF, 1'b1, 1'b1, 16'h0000);
    run_access("len17_reject", 2'd3, 5'd17, 16'hFFFF, 1'b1, 1'b1, 16'h0000);

    // Start held high across an access: one capture, next only after done.
    preload(2'd0, 5'd8, 16'h0077);
    sb.push_back('{rd: 16'h0077, err: 1'b0, lat: 11});
    sb.push_back('{rd: 16'h00C3, err: 1'b0, lat: 11});
    @(negedge clk);
    bus.start = 1'b1; bus.chain_sel = 2'd0; bus.chain_len = 5'd8; bus.wr_data = 16'h5AC3;
    bus.do_update = 1'b1; bus.test_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cap = 0; n_done = 0; cap2 = -1; base = 0;
    for (int c = 1; c <= 60; c++) begin
      if (capture_en) begin
        n_cap++;
        if (c > 1) begin cap2 = c; base = c - 1; bus.start = 1'b0; end
      end
      if (bus.done === 1'b1) begin
        n_done++;
        sb_retire(n_done == 1 ? "hold_first" : "hold_second", c - base);
        if (n_done == 2) break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_val("hold_capture_count", 32'(n_cap), 32'd2);
    check_val("hold_second_capture_cycle", 32'(cap2), 32'd13);
    check_val("hold_done_count", 32'(n_done), 32'd2);
    last_rd = 16'h00C3; last_sel = 2'd0; last_mode = 1'b1;
    @(negedge clk);

    // Reset in the middle of a 10-cell shift.
    preload(2'd3, 5'd10, 16'h02A5);
    @(negedge clk);
    bus.start = 1'b1; bus.chain_sel = 2'd3; bus.chain_len = 5'd10; bus.wr_data = 16'h0155;
    bus.do_update = 1'b1; bus.test_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_outputs", 32'({bus.busy, bus.done, bus.error, capture_en, shift_dr,
              update_en, mode, scan_out, mux_select}), 32'd0);
    check_val("abort_rd_data", 32'(bus.rd_data), 32'd0);
    busy_seen = 1'b0; acc = '0;
    repeat (15) begin
      @(negedge clk);
      busy_seen |= bus.busy;
      acc[0] |= bus.done;
    end
    check_val("abort_no_done", 32'(acc[0]), 32'd0);
    check_val("abort_stays_idle", 32'(busy_seen), 32'd0);
    last_rd = '0; last_sel = '0; last_mode = 1'b0;
    preload(2'd3, 5'd10, 16'h02A5);
    run_access("after_abort", 2'd3, 5'd10, 16'h0155, 1'b1, 1'b0, 16'h02A5);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
